add_elem_stream_ctrl: RTL and testbench

- Operand-feeding and result-collecting controller for the int8 element-wise ADD pipeline.
- Streams element pairs from two operand SRAMs into the pipeline's in1/in2/input_valid port.
- Captures the pipeline's out/valid results in a local FIFO and writes them back to an output SRAM.
- The ADD pipeline cannot stall, so this block enforces a credit scheme. Results can then never be lost, whatever the pipeline latency.

---
 rtl/add_elem_stream_ctrl.sv | 249 ++++++++++++++++++++++++
 tb/tb_add_elem_stream_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/add_elem_stream_ctrl.sv
// add_elem_stream_ctrl
// Feeds element pairs from two operand SRAMs into a non-stallable int8 ADD
// pipeline and writes its results back to an output SRAM. A credit counter
// limits elements in flight to the result FIFO depth. A result therefore
// always finds a free FIFO slot, whatever the pipeline latency.

module add_elem_stream_ctrl #(
  parameter int ADDR_W     = 16,
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  // job control
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] base_o,
  output logic              busy,
  output logic              done,
  // operand SRAM read port
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  input  logic [7:0]        rd_data_a,
  input  logic [7:0]        rd_data_b,
  // ADD pipeline
  output logic              add_valid,
  output logic [7:0]        add_in1,
  output logic [7:0]        add_in2,
  input  logic [7:0]        add_out,
  input  logic              add_out_valid,
  // output SRAM write port
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  input  logic              wr_ready,
  // error
  output logic              overflow
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t            r_state;
  logic [LEN_W-1:0]  r_len;
  logic [ADDR_W-1:0] r_base_a;
  logic [ADDR_W-1:0] r_base_b;
  logic [ADDR_W-1:0] r_base_o;
  logic [LEN_W-1:0]  r_issue_cnt;
  logic [LEN_W-1:0]  r_wr_cnt;
  logic [CNT_W-1:0]  r_credits;
  logic              r_busy;
  logic              r_done;
  logic              r_rd_vld;     // rd_en delayed one cycle: SRAM data valid now
  logic              r_add_valid;
  logic [7:0]        r_add_in1;
  logic [7:0]        r_add_in2;
  logic              r_overflow;

  logic [7:0]        r_fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_fifo_cnt;

  // ---------------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------------
  state_t w_state_nxt;
  logic   w_start;
  logic   w_issue;
  logic   w_wr_en;
  logic   w_pop;
  logic   w_push_req;
  logic   w_full;
  logic   w_push;
  logic   w_drop;

  assign w_start    = (r_state == S_IDLE) && start;
  assign w_issue    = (r_state == S_RUN) && (r_issue_cnt < r_len) && (r_credits != '0);
  assign w_wr_en    = r_busy && (r_fifo_cnt != '0);
  assign w_pop      = w_wr_en && wr_ready;
  // Results arriving outside a job are stale (abort/reset) and are discarded.
  assign w_push_req = add_out_valid && r_busy;
  assign w_full     = (r_fifo_cnt == DEPTH_C);
  // A full FIFO still accepts a push when it pops in the same cycle.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;

  // Next-state logic for the job FSM.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (len == '0) ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        if (r_wr_cnt == r_len) begin
          w_state_nxt = S_FIN;
        end
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register plus registered busy/done; done follows FIN by one cycle,
  // in the same cycle that busy falls.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (r_state == S_FIN);
    end
  end

  // Job parameters, latched on an accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_len    <= '0;
      r_base_a <= '0;
      r_base_b <= '0;
      r_base_o <= '0;
    end else if (w_start) begin
      r_len    <= len;
      r_base_a <= base_a;
      r_base_b <= base_b;
      r_base_o <= base_o;
    end
  end

  // Issue and write-back counters; both restart on an accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_issue_cnt <= '0;
      r_wr_cnt    <= '0;
    end else if (w_start) begin
      r_issue_cnt <= '0;
      r_wr_cnt    <= '0;
    end else begin
      if (w_issue) r_issue_cnt <= r_issue_cnt + LEN_W'(1);
      if (w_pop)   r_wr_cnt    <= r_wr_cnt + LEN_W'(1);
    end
  end

  // Credits: one per free result slot; an issue takes one, a write-back returns one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_credits <= DEPTH_C;
    end else begin
      unique case ({w_issue, w_pop})
        2'b10:   r_credits <= r_credits - CNT_W'(1);
        2'b01:   r_credits <= r_credits + CNT_W'(1);
        default: r_credits <= r_credits;
      endcase
    end
  end

  // Operand forwarding: SRAM data is valid the cycle after rd_en; it is
  // registered then and presented with add_valid so both line up at the pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_vld    <= 1'b0;
      r_add_valid <= 1'b0;
      r_add_in1   <= '0;
      r_add_in2   <= '0;
    end else begin
      r_rd_vld    <= w_issue;
      r_add_valid <= r_rd_vld;
      if (r_rd_vld) begin
        r_add_in1 <= rd_data_a;
        r_add_in2 <= rd_data_b;
      end
    end
  end

  // Result FIFO storage.
  // NOTE: the storage array has no reset; only pointers/count are reset, and wr_data is gated while empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_mem[r_wr_ptr] <= add_out;
    end
  end

  // Result FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + CNT_W'(1);
        2'b01:   r_fifo_cnt <= r_fifo_cnt - CNT_W'(1);
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy      = r_busy;
  assign done      = r_done;
  assign rd_en     = w_issue;
  assign rd_addr_a = r_base_a + ADDR_W'(r_issue_cnt);
  assign rd_addr_b = r_base_b + ADDR_W'(r_issue_cnt);
  assign add_valid = r_add_valid;
  assign add_in1   = r_add_in1;
  assign add_in2   = r_add_in2;
  assign wr_en     = w_wr_en;
  assign wr_addr   = r_base_o + ADDR_W'(r_wr_cnt);
  assign wr_data   = w_wr_en ? r_fifo_mem[r_rd_ptr] : 8'h00;
  assign overflow  = r_overflow;

  // ---------------------------------------------------------------------------
  // Invariants: credits cap outstanding work, so a push is never dropped.
  // ---------------------------------------------------------------------------
  a_no_drop: assert property (@(posedge clk) disable iff (!rst) !w_drop);
  a_credit_cap: assert property (@(posedge clk) disable iff (!rst) r_credits <= DEPTH_C);

endmodule

// File: tb/tb_add_elem_stream_ctrl.sv
// Testbench for add_elem_stream_ctrl: SRAM and saturating ADD pipeline models,
// a write monitor, and an expected-result model built from the job parameters.

module tb_add_elem_stream_ctrl;

  localparam int ADDR_W = 16;
  localparam int LEN_W  = 16;
  localparam int DEPTH  = 8;
  localparam int LAT    = 7;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [LEN_W-1:0]  len = '0;
  logic [ADDR_W-1:0] base_a = '0, base_b = '0, base_o = '0;
  logic              busy, done, rd_en;
  logic [ADDR_W-1:0] rd_addr_a, rd_addr_b;
  logic [7:0]        rd_data_a = '0, rd_data_b = '0;
  logic              add_valid;
  logic [7:0]        add_in1, add_in2;
  logic [7:0]        add_out;
  logic              add_out_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              wr_ready = 1'b0;
  logic              overflow;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  add_elem_stream_ctrl #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .base_a(base_a), .base_b(base_b), .base_o(base_o),
    .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .add_valid(add_valid), .add_in1(add_in1), .add_in2(add_in2),
    .add_out(add_out), .add_out_valid(add_out_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .overflow(overflow)
  );

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    if (s > 127) s = 127;
    else if (s < -128) s = -128;
    return s[7:0];
  endfunction

  // Operand SRAMs: data appears the cycle after the read strobe.
  logic [7:0] mem_a [0:65535];
  logic [7:0] mem_b [0:65535];
  always @(posedge clk) begin
    if (rd_en) begin
      rd_data_a <= mem_a[rd_addr_a];
      rd_data_b <= mem_b[rd_addr_b];
    end
  end

  // Saturating ADD pipeline with fixed latency; never reset, never stalls.
  logic       pipe_v [LAT];
  logic [7:0] pipe_d [LAT];
  initial for (int i = 0; i < LAT; i++) begin pipe_v[i] = 1'b0; pipe_d[i] = 8'h00; end
  always @(posedge clk) begin
    pipe_v[0] <= add_valid;
    pipe_d[0] <= sat_add(add_in1, add_in2);
    for (int i = 1; i < LAT; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_d[i] <= pipe_d[i-1];
    end
  end
  assign add_out_valid = pipe_v[LAT-1];
  assign add_out       = pipe_d[LAT-1];

  // Monitor, sampled on the falling edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] obs_addr [$];
  logic [7:0]  obs_data [$];
  logic [15:0] rda_q [$];
  int rd_cnt = 0, wr_any = 0, done_cnt = 0, start_cyc = 0, done_cyc = 0;
  logic busy_at_done = 1'b0;
  always @(negedge clk) begin
    if (rd_en) begin rd_cnt++; rda_q.push_back(rd_addr_a); end
    if (wr_en) wr_any++;
    if (wr_en && wr_ready) begin obs_addr.push_back(wr_addr); obs_data.push_back(wr_data); end
    if (done) begin done_cnt++; done_cyc = cyc; busy_at_done = busy; end
    if (start) start_cyc = cyc;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // rdy_mode: 0 = always ready, 1 = random ready, 2 = not ready for 'hold' cycles.
  task automatic run_job(input string tag, input int len_i, input logic [15:0] ba,
                         input logic [15:0] bb, input logic [15:0] bo, input bit fill,
                         input int rdy_mode, input int hold, input int extra_start_at);
    int w0, d0, r0, n_obs, n_cmp;
    bit got_done;
    logic [15:0] e_addr;
    logic [7:0]  e_data;
    if (fill) begin
      for (int i = 0; i < len_i; i++) begin
        mem_a[16'(ba + i)] = 8'($urandom);
        mem_b[16'(bb + i)] = 8'($urandom);
      end
    end
    w0 = obs_addr.size(); d0 = done_cnt; r0 = rd_cnt;
    start = 1'b1; len = LEN_W'(len_i); base_a = ba; base_b = bb; base_o = bo;
    wr_ready = (rdy_mode != 2);
    @(posedge clk); #1;
    start = 1'b0;
    got_done = 1'b0;
    for (int c = 0; c < 3000 && !got_done; c++) begin
      case (rdy_mode)
        0: wr_ready = 1'b1;
        1: wr_ready = 1'($urandom_range(0, 1));
        default: begin
          if (c == hold) check({tag, "_issue_stall"}, rd_cnt - r0, DEPTH);
          wr_ready = (c >= hold);
        end
      endcase
      if (c == extra_start_at) begin start = 1'b1; len = LEN_W'(3); end
      else start = 1'b0;
      @(posedge clk); #1;
      if (done_cnt > d0) got_done = 1'b1;
    end
    start = 1'b0;
    check({tag, "_done_seen"}, got_done, 1);
    check({tag, "_busy_at_done"}, busy_at_done, 0);
    repeat (LAT + 12) @(posedge clk);
    #1;
    check({tag, "_busy_low"}, busy, 0);
    check({tag, "_done_count"}, done_cnt - d0, 1);
    check({tag, "_rd_count"}, rd_cnt - r0, len_i);
    n_obs = obs_addr.size() - w0;
    check({tag, "_n_writes"}, n_obs, len_i);
    n_cmp = (n_obs < len_i) ? n_obs : len_i;
    for (int i = 0; i < n_cmp; i++) begin
      e_addr = 16'(bo + i);
      e_data = sat_add(mem_a[16'(ba + i)], mem_b[16'(bb + i)]);
      check($sformatf("%s_addr%0d", tag, i), obs_addr[w0 + i], e_addr);
      check($sformatf("%s_data%0d", tag, i), obs_data[w0 + i], e_data);
    end
    check({tag, "_overflow"}, overflow, 0);
  endtask

  initial begin
    int w0, r0, q0, wa, d0;
    logic [15:0] ba, bb, bo;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", {busy, done, rd_en, wr_en, add_valid, overflow}, 0);
    check("rst_addr", {rd_addr_a, rd_addr_b, wr_addr}, 0);
    check("rst_data", {add_in1, add_in2, wr_data}, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Basic job with fixed operands
    for (int i = 0; i < 4; i++) begin
      mem_a[16'h0010 + 16'(i)] = 8'(i + 1);
      mem_b[16'h0040 + 16'(i)] = 8'(10 * (i + 1));
    end
    w0 = obs_addr.size();
    run_job("basic", 4, 16'h0010, 16'h0040, 16'h0100, 1'b0, 0, 0, -1);
    check("basic_w0", obs_data[w0 + 0], 11);
    check("basic_w3", obs_data[w0 + 3], 44);
    check("basic_a3", obs_addr[w0 + 3], 16'h0103);

    // Saturation in both directions
    mem_a[16'h0200] = 8'd100; mem_b[16'h0300] = 8'd100;
    mem_a[16'h0201] = 8'h80;  mem_b[16'h0301] = 8'hF0;
    w0 = obs_addr.size();
    run_job("sat", 2, 16'h0200, 16'h0300, 16'h0400, 1'b0, 0, 0, -1);
    check("sat_pos", obs_data[w0 + 0], 8'h7F);
    check("sat_neg", obs_data[w0 + 1], 8'h80);

    // Backpressure
    run_job("bp", 20, 16'h1000, 16'h2000, 16'h3000, 1'b1, 2, 40, -1);

    // Zero-length job
    r0 = rd_cnt; wa = wr_any;
    run_job("zero", 0, 16'h0000, 16'h0000, 16'h0500, 1'b0, 0, 0, -1);
    check("zero_done_lat", done_cyc - start_cyc, 2);
    check("zero_no_wr", wr_any - wa, 0);

    // Start while busy is ignored
    run_job("busy_start", 6, 16'h0600, 16'h0700, 16'h0800, 1'b1, 0, 0, 3);

    // Reset mid-job
    for (int i = 0; i < 10; i++) begin
      mem_a[16'h0900 + 16'(i)] = 8'($urandom);
      mem_b[16'h0A00 + 16'(i)] = 8'($urandom);
    end
    r0 = rd_cnt; d0 = done_cnt;
    start = 1'b1; len = 16'd10; base_a = 16'h0900; base_b = 16'h0A00; base_o = 16'h0B00;
    wr_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 100 && (rd_cnt - r0) < 3; c++) begin
      @(posedge clk); #1;
    end
    check("mid_issued", rd_cnt - r0, 3);
    rst = 1'b0;
    #1;
    check("mid_rst_ctrl", {busy, done, rd_en, wr_en, add_valid, overflow}, 0);
    check("mid_rst_addr", {rd_addr_a, rd_addr_b, wr_addr}, 0);
    check("mid_rst_data", {add_in1, add_in2, wr_data}, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    wa = wr_any;
    repeat (LAT + 10) @(posedge clk);
    #1;
    check("mid_discard", wr_any - wa, 0);
    check("mid_no_done", done_cnt - d0, 0);
    run_job("after_rst", 2, 16'h0C00, 16'h0D00, 16'h0E00, 1'b1, 0, 0, -1);

    // Address wrap
    q0 = rda_q.size();
    run_job("wrap", 4, 16'hFFFE, 16'hFFFF, 16'hFFFD, 1'b1, 0, 0, -1);
    for (int i = 0; i < 4; i++) begin
      if (q0 + i < rda_q.size())
        check($sformatf("wrap_rda%0d", i), rda_q[q0 + i], 16'(16'hFFFE + i));
      else
        check($sformatf("wrap_rda%0d", i), 32'hFFFF_FFFF, 16'(16'hFFFE + i));
    end

    // Randomized jobs with random write backpressure
    for (int j = 0; j < 6; j++) begin
      ba = 16'($urandom); bb = 16'($urandom); bo = 16'($urandom);
      run_job($sformatf("rand%0d", j), $urandom_range(1, 24), ba, bb, bo, 1'b1, 1, 0, -1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
